// File: rtl/muls_pkg.sv
// ---------------------------------------------------------------------------
// muls_pkg
// Shared definitions for the iterative signed multiplier (muls_8).
//   - muls_state_e : FSM state type. The encoding matches the iterative signed
//                    divider, so one ALU controller decode serves both blocks.
//   - MULS_WIDTH   : default operand width.
//   - MULS_CNT_W   : width of the iteration counter for the default width.
// ---------------------------------------------------------------------------
package muls_pkg;

    localparam int MULS_WIDTH = 8;
    localparam int MULS_CNT_W = $clog2(MULS_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESL = 2'b11
    } muls_state_e;

endpackage : muls_pkg

// File: rtl/muls_8.sv
// ---------------------------------------------------------------------------
// muls_8
// Sequential signed multiplier. The block takes the magnitudes of both
// two's-complement operands, runs a shift-add loop on them (one multiplier
// bit per clock), and applies the product sign in a final cycle. It uses the
// same start/done handshake as the iterative signed divider.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request pulse, only looked at while idle
//   src1   in   [WIDTH-1:0]   signed multiplicand
//   src2   in   [WIDTH-1:0]   signed multiplier
//   P      out  [2*WIDTH-1:0] signed product, held until the next result
//   busy   out  high while an operation is in flight (CALC or RESL)
//   done   out  one-cycle pulse in the cycle P takes its new value
//
// Optional build macro
//   MULS_EARLY_EXIT_EN : leave CALC as soon as the remaining multiplier bits
//                        are all zero. Results are unchanged; only the
//                        latency becomes data dependent (3 .. WIDTH+2 edges).
// ---------------------------------------------------------------------------
module muls_8
    import muls_pkg::*;
#(
    parameter int WIDTH = MULS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    muls_state_e        state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PW-1:0]      p_q, p_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand magnitudes. The most negative input maps to 2^(WIDTH-1), which
    // still fits in WIDTH unsigned bits, so no extra bit is needed.
    logic [WIDTH-1:0]   mag1, mag2;

    // Magnitude of each operand, taken from the live inputs so it can be
    // latched in the same cycle start is seen.
    always_comb begin
        mag1 = src1[WIDTH-1] ? (~src1 + WIDTH'(1)) : src1;
        mag2 = src2[WIDTH-1] ? (~src2 + WIDTH'(1)) : src2;
    end

    // Next-state and datapath logic. Every register holds by default; done
    // defaults low so it can only ever be a single-cycle pulse out of RESL.
    always_comb begin
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        p_d      = p_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    s1_d     = src1[WIDTH-1];
                    s2_d     = src2[WIDTH-1];
                    mcand_d  = {{WIDTH{1'b0}}, mag1};
                    mplier_d = mag2;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = CALC;
                end
            end

            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
`ifdef MULS_EARLY_EXIT_EN
                // Once the remaining multiplier bits are zero, every further
                // iteration would add nothing, so the loop can stop early.
                if ((count_d == CNT_W'(WIDTH)) || (mplier_d == '0)) begin
                    state_d = RESL;
                end
`else
                if (count_d == CNT_W'(WIDTH)) begin
                    state_d = RESL;
                end
`endif
            end

            RESL: begin
                // Negating a zero accumulator yields zero, so a zero operand
                // gives P=0 regardless of the operand signs.
                p_d     = (s1_q ^ s2_q) ? (~acc_q + PW'(1)) : acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : muls_8

// File: tb/tb_muls_8.sv
// ---------------------------------------------------------------------------
// tb_muls_8
// Directed testbench for muls_8 (WIDTH=8): reset, sign quadrants, extremes,
// zero operands, start-while-busy, back-to-back starts and a short random
// sweep against the signed product. Build with MULS_EARLY_EXIT_EN defined to
// match an early-exit build of the design.
// ---------------------------------------------------------------------------
module tb_muls_8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  src1;
    logic [7:0]  src2;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    muls_8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src1  (src1),
        .src2  (src2),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts done pulses seen at rising edges, for the sweep accounting.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Expected number of edges from the accepting edge (edge 1) through the
    // edge that raises done.
    function automatic int exp_lat(input logic [7:0] b);
`ifdef MULS_EARLY_EXIT_EN
        logic [7:0] m;
        int it;
        m  = b[7] ? (~b + 8'd1) : b;
        it = 0;
        do begin
            m  = m >> 1;
            it = it + 1;
        end while (m != 8'd0 && it < 8);
        return it + 2;
`else
        return 10;
`endif
    endfunction

    // Presents one operation right after an edge (edge 0), and returns the
    // edge number after which done was first seen (0 on timeout). When
    // glitch_edge is non-zero, start is pulsed with other operands after that
    // edge, while the block should still be busy.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input int glitch_edge, output int lat);
        @(posedge clk); #1;
        src1  = a;
        src2  = b;
        start = 1'b1;
        lat   = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 1) start = 1'b0;
            if (glitch_edge != 0 && e == glitch_edge) begin
                start = 1'b1;
                src1  = 8'd100;
                src2  = 8'd100;
            end
            if (glitch_edge != 0 && e == glitch_edge + 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen_done;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (P !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_P: got %h, want 0000", P);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_done: got %b, want 0", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b, want 0", busy);
        end

        // Start 7*5 after edge 0, accepted at edge 1, reset lands on edge 4.
        @(posedge clk); #1;
        src1 = 8'd7; src2 = 8'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midcalc_busy_before_reset: got %b, want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midcalc_reset_busy: got %b, want 0", busy);
        end
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0) seen_done = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("[TB] FAIL midcalc_reset_no_done: got done pulse, want none");
        end
        checks++;
        if (P !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midcalc_reset_P: got %h, want 0000", P);
        end
    endtask

    task automatic test_quadrants();
        logic [7:0]  av [4];
        logic [7:0]  bv [4];
        logic [15:0] pv [4];
        int lat;
        av = '{8'd7, 8'hF9, 8'd7,  8'hF9};
        bv = '{8'd5, 8'd5,  8'hFB, 8'hFB};
        pv = '{16'd35, 16'hFFDD, 16'hFFDD, 16'd35};
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], bv[i], 0, lat);
            checks++;
            if (lat != exp_lat(bv[i])) begin
                errors++;
                $display("[TB] FAIL quad%0d_latency: got %0d edges, want %0d", i, lat, exp_lat(bv[i]));
            end
            checks++;
            if (P !== pv[i]) begin
                errors++;
                $display("[TB] FAIL quad%0d_P: got %h, want %h", i, P, pv[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL quad%0d_done_width: got %b one cycle later, want 0", i, done);
            end
        end
    endtask

    task automatic test_extremes();
        logic [7:0]  av [3];
        logic [7:0]  bv [3];
        logic [15:0] pv [3];
        int lat;
        av = '{8'h80, 8'h80, 8'h7F};
        bv = '{8'h80, 8'h7F, 8'h7F};
        pv = '{16'h4000, 16'hC080, 16'd16129};
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], 0, lat);
            checks++;
            if (lat == 0 || P !== pv[i]) begin
                errors++;
                $display("[TB] FAIL extreme%0d_P: got %h (lat %0d), want %h", i, P, lat, pv[i]);
            end
        end
    endtask

    task automatic test_zero();
        int lat;
        do_op(8'd0, 8'hFF, 0, lat);
        checks++;
        if (lat == 0 || P !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL zero_0xm1: got %h (lat %0d), want 0000", P, lat);
        end
        // Preload a non-zero P so the next zero result is a visible change.
        do_op(8'd3, 8'd3, 0, lat);
        do_op(8'hFF, 8'd0, 0, lat);
        checks++;
        if (lat == 0 || P !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL zero_m1x0: got %h (lat %0d), want 0000", P, lat);
        end
        do_op(8'd5, 8'd0, 0, lat);
        checks++;
        if (lat != exp_lat(8'd0)) begin
            errors++;
            $display("[TB] FAIL zero_5x0_latency: got %0d edges, want %0d", lat, exp_lat(8'd0));
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        do_op(8'd7, 8'd5, 3, lat);
        checks++;
        if (lat != exp_lat(8'd5)) begin
            errors++;
            $display("[TB] FAIL busy_start_latency: got %0d edges, want %0d", lat, exp_lat(8'd5));
        end
        checks++;
        if (P !== 16'd35) begin
            errors++;
            $display("[TB] FAIL busy_start_P: got %h, want 0023", P);
        end
        // Nothing else may complete: the ignored start must not spawn an op.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) begin
                checks++;
                errors++;
                $display("[TB] FAIL busy_start_extra_done: got done=1 at idle cycle %0d, want 0", i);
                break;
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int lat2;
        do_op(8'd7, 8'd5, 0, lat);
        checks++;
        if (lat == 0 || P !== 16'd35) begin
            errors++;
            $display("[TB] FAIL b2b_first_P: got %h (lat %0d), want 0023", P, lat);
        end
        // Still inside the done cycle: present the next request now.
        src1  = 8'd3;
        src2  = 8'hFC;
        start = 1'b1;
        lat2  = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 1) start = 1'b0;
            if (done === 1'b1) begin
                lat2 = e;
                break;
            end
        end
        checks++;
        if (lat2 != exp_lat(8'hFC)) begin
            errors++;
            $display("[TB] FAIL b2b_latency: got %0d edges, want %0d", lat2, exp_lat(8'hFC));
        end
        checks++;
        if (P !== 16'hFFF4) begin
            errors++;
            $display("[TB] FAIL b2b_second_P: got %h, want fff4", P);
        end
    endtask

    task automatic test_sweep();
        logic signed [7:0]  sa;
        logic signed [7:0]  sb;
        logic signed [15:0] expv;
        int lat;
        int bad;
        int d0;
        int n;
        bad = 0;
        n   = 300;
        @(posedge clk); #1;
        d0 = done_cnt;
        for (int i = 0; i < n; i++) begin
            sa   = 8'($urandom_range(0, 255));
            sb   = 8'($urandom_range(0, 255));
            expv = sa * sb;
            do_op(sa, sb, 0, lat);
            if (lat == 0 || P !== expv) begin
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL sweep_P: %0d*%0d got %h (lat %0d), want %h", sa, sb, P, lat, expv);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL sweep_summary: got %0d wrong products, want 0", bad);
        end
        checks++;
        if (done_cnt - d0 != n) begin
            errors++;
            $display("[TB] FAIL sweep_done_count: got %0d done pulses, want %0d", done_cnt - d0, n);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        src1  = 8'd0;
        src2  = 8'd0;
        test_reset();
        test_quadrants();
        test_extremes();
        test_zero();
        test_start_while_busy();
        test_back_to_back();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Last-resort bound on total run time.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_muls_8
